// File: rtl/mandel_iter.sv
// mandel_iter -- per-pixel Mandelbrot escape-time engine.
//
// Takes one signed screen coordinate per input handshake. It maps the
// coordinate to c = center + coord*scale in Q(W-FRAC).FRAC. It then iterates
// z <- z^2 + c from z = 0 until |z|^2 > 4 or the count reaches MAX_ITER.
// The iteration count is returned together with the pixel's frame/line flags.
//
// Ports
//   out_stream_aclk          clock
//   periph_reset             asynchronous active-high reset
//   in_valid / in_ready      coordinate handshake
//   in_re, in_im             signed pixel column / row
//   in_first, in_last        start-of-frame / end-of-line flags
//   scale                    unsigned complex-plane step per pixel
//   center_re, center_im     signed complex-plane offset
//   out_valid / out_ready    result handshake
//   out_iter                 escape count
//   out_first, out_last      flags of the pixel that produced out_iter
//
// Optional feature: define MANDEL_ITER_PREFETCH_EN to add a one-entry holding
// register. It accepts the next coordinate while the current pixel is still
// iterating.

module mandel_iter #(
    parameter int W        = 18,
    parameter int FRAC     = 12,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [9:0]        in_re,
    input  logic signed [8:0]        in_im,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [W-1:0]             scale,
    input  logic signed [W-1:0]      center_re,
    input  logic signed [W-1:0]      center_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ITER_W-1:0]        out_iter,
    output logic                     out_first,
    output logic                     out_last
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAP  = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int PW = 2 * W;
    // 4.0 in the fixed-point format. It is held at the width of the
    // escape-test sum.
    localparam logic signed [PW:0] ESC_LIM = {{(PW-FRAC-2){1'b0}}, 3'b100, {FRAC{1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ITER_W-1:0]   out_iter_q, out_iter_d;
    logic                first_q, last_q;
    logic signed [9:0]   re_q;
    logic signed [8:0]   im_q;
    logic signed [W-1:0] c_re_q, c_im_q;
    logic signed [W-1:0] zr_q, zi_q;

    logic                load_pix;
    logic                pix_avail;
    logic signed [9:0]   src_re;
    logic signed [8:0]   src_im;
    logic                src_first, src_last;

`ifdef MANDEL_ITER_PREFETCH_EN
    logic                hold_full_q, hold_full_d;
    logic signed [9:0]   hold_re_q;
    logic signed [8:0]   hold_im_q;
    logic                hold_first_q, hold_last_q;
    logic                hold_load, hold_drain;

    assign in_ready   = !periph_reset && !hold_full_q;
    // A coordinate that arrives while the FSM is idle with an empty hold
    // bypasses straight into MAP. Any other accepted coordinate is parked.
    assign hold_load  = in_valid && in_ready && !((state_q == S_IDLE) && !hold_full_q);
    assign hold_drain = load_pix && hold_full_q;
    assign pix_avail  = hold_full_q || in_valid;

    always_comb begin
        src_re    = in_re;
        src_im    = in_im;
        src_first = in_first;
        src_last  = in_last;
        if (hold_full_q) begin
            src_re    = hold_re_q;
            src_im    = hold_im_q;
            src_first = hold_first_q;
            src_last  = hold_last_q;
        end
    end

    always_comb begin
        hold_full_d = hold_full_q;
        if (hold_load)
            hold_full_d = 1'b1;
        else if (hold_drain)
            hold_full_d = 1'b0;
    end

    always_ff @(posedge out_stream_aclk) begin
        if (hold_load) begin
            hold_re_q    <= in_re;
            hold_im_q    <= in_im;
            hold_first_q <= in_first;
            hold_last_q  <= in_last;
        end
    end
`else
    assign in_ready  = !periph_reset && (state_q == S_IDLE);
    assign pix_avail = in_valid;

    always_comb begin
        src_re    = in_re;
        src_im    = in_im;
        src_first = in_first;
        src_last  = in_last;
    end
`endif

    // Coordinate mapping. scale is zero-extended so that it multiplies as an
    // unsigned magnitude. Products and sums wrap at W bits.
    logic signed [W:0]    scale_s;
    logic signed [W+10:0] p_re;
    logic signed [W+9:0]  p_im;
    logic signed [W-1:0]  map_re, map_im;

    assign scale_s = {1'b0, scale};
    assign p_re    = re_q * scale_s;
    assign p_im    = im_q * scale_s;
    assign map_re  = center_re + W'(p_re);
    assign map_im  = center_im + W'(p_im);

    // One iteration step. The squares keep their full precision, so the
    // escape sum cannot wrap even when c lies far outside the set.
    logic signed [PW-1:0] zr_sq, zi_sq, zr_zi;
    logic signed [PW-1:0] zr2, zi2;
    logic signed [W-1:0]  zri;
    logic signed [PW:0]   mag;
    logic                 escape;
    logic signed [W-1:0]  zr_nx, zi_nx;

    assign zr_sq  = zr_q * zr_q;
    assign zi_sq  = zi_q * zi_q;
    assign zr_zi  = zr_q * zi_q;
    assign zr2    = zr_sq >>> FRAC;
    assign zi2    = zi_sq >>> FRAC;
    // Shifting by one bit less than FRAC yields 2*zr*zi.
    assign zri    = W'(zr_zi >>> (FRAC - 1));
    assign mag    = {zr2[PW-1], zr2} + {zi2[PW-1], zi2};
    assign escape = mag > ESC_LIM;
    assign zr_nx  = W'(zr2 - zi2) + c_re_q;
    assign zi_nx  = zri + c_im_q;

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        out_iter_d = out_iter_q;
        load_pix   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pix_avail) begin
                    load_pix = 1'b1;
                    state_d  = S_MAP;
                end
            end
            S_MAP: begin
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (escape || (iter_q == ITER_W'(MAX_ITER))) begin
                    out_iter_d = iter_q;
                    state_d    = S_OUT;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
`ifdef MANDEL_ITER_PREFETCH_EN
                    // A parked coordinate starts immediately, so there is no
                    // idle cycle between pixels.
                    if (hold_full_q) begin
                        load_pix = 1'b1;
                        state_d  = S_MAP;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q     <= S_IDLE;
            iter_q      <= '0;
            out_iter_q  <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
`ifdef MANDEL_ITER_PREFETCH_EN
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            out_iter_q  <= out_iter_d;
            if (load_pix) begin
                first_q <= src_first;
                last_q  <= src_last;
            end
`ifdef MANDEL_ITER_PREFETCH_EN
            hold_full_q <= hold_full_d;
`endif
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (load_pix) begin
            re_q <= src_re;
            im_q <= src_im;
        end
        if (state_q == S_MAP) begin
            c_re_q <= map_re;
            c_im_q <= map_im;
            zr_q   <= '0;
            zi_q   <= '0;
        end else if (state_q == S_ITER) begin
            zr_q <= zr_nx;
            zi_q <= zi_nx;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_iter  = out_iter_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_mandel_iter.sv
module tb_mandel_iter;

    localparam int W        = 18;
    localparam int FRAC     = 12;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 255;
`ifdef MANDEL_ITER_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic                 clk;
    logic                 periph_reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [9:0]    in_re;
    logic signed [8:0]    in_im;
    logic                 in_first;
    logic                 in_last;
    logic [W-1:0]         scale;
    logic signed [W-1:0]  center_re;
    logic signed [W-1:0]  center_im;
    logic                 out_valid;
    logic                 out_ready;
    logic [ITER_W-1:0]    out_iter;
    logic                 out_first;
    logic                 out_last;

    mandel_iter #(.W(W), .FRAC(FRAC), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .out_stream_aclk(clk),
        .periph_reset(periph_reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_re(in_re),
        .in_im(in_im),
        .in_first(in_first),
        .in_last(in_last),
        .scale(scale),
        .center_re(center_re),
        .center_im(center_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_iter(out_iter),
        .out_first(out_first),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int re;
        int im;
        int first;
        int last;
        int scale;
        int cre;
        int cim;
        int hold;
        int exp_iter;
        int exp_lat;
    } vec_t;

    vec_t vt[9];

    task automatic set_pixel(input vec_t v);
        scale     = W'(v.scale);
        center_re = W'(v.cre);
        center_im = W'(v.cim);
        in_re     = 10'(v.re);
        in_im     = 9'(v.im);
        in_first  = (v.first != 0);
        in_last   = (v.last != 0);
    endtask

    // Called #1 after an active edge. Returns #1 after the result handshake.
    task automatic apply(input vec_t v, input string tag);
        int waited;
        int lat;
        waited = 0;
        lat    = 0;
        set_pixel(v);
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, " accept wait"}, waited, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " in_ready in MAP"}, int'(in_ready), PF);
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " out_iter"}, int'(out_iter), v.exp_iter);
        chk({tag, " out_first"}, int'(out_first), v.first);
        chk({tag, " out_last"}, int'(out_last), v.last);
        chk({tag, " in_ready in OUT"}, int'(in_ready), PF);
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk); #1;
            chk({tag, " held out_valid"}, int'(out_valid), 1);
            chk({tag, " held out_iter"}, int'(out_iter), v.exp_iter);
            chk({tag, " held out_first"}, int'(out_first), v.first);
            chk({tag, " held out_last"}, int'(out_last), v.last);
            chk({tag, " held in_ready"}, int'(in_ready), PF);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, int'(out_valid), 0);
        chk({tag, " in_ready after handshake"}, int'(in_ready), 1);
    endtask

    initial begin
        vec_t r;
        int   lat;

        //            re    im  f  l  scale     cre    cim  hold iter  lat
        vt[0] = '{    0,    0, 0, 0,     16,      0,     0,  0,  255, 257}; // interior
        vt[1] = '{  319,  240, 0, 1,     16,      0,     0,  0,    2,   4}; // fast escape
        vt[2] = '{    0,    0, 0, 0,      0,  -8192,     0,  0,  255, 257}; // c=-2, |z|^2 == 4
        vt[3] = '{    0,    0, 1, 0,      0,  -8193,     0,  0,    1,   3}; // just past -2
        vt[4] = '{ -320, -239, 1, 0,     16,      0,     0,  0,    3,   5}; // negative corner
        vt[5] = '{    2,    0, 0, 0, 131072,      0,     0,  0,  255, 257}; // product wraps to 0
        vt[6] = '{    0,    0, 0, 1,      0,      0,  8192,  0,    2,   4}; // c=2i
        vt[7] = '{  319,  240, 0, 1,     16,      0,     0, 10,    2,   4}; // backpressure
        vt[8] = '{    0,    0, 1, 1,      0,  -8193,     0,  0,    1,   3}; // right after release

        periph_reset = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_re        = '0;
        in_im        = '0;
        in_first     = 1'b0;
        in_last      = 1'b0;
        scale        = '0;
        center_re    = '0;
        center_im    = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_iter", int'(out_iter), 0);
        chk("reset out_first", int'(out_first), 0);
        chk("reset out_last", int'(out_last), 0);
        chk("reset in_ready", int'(in_ready), 0);
        periph_reset = 1'b0;
        #1;
        chk("in_ready after reset", int'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
        end

        // Reset during the interior pixel at iteration 100.
        r = vt[0];
        set_pixel(r);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        chk("midrun out_valid", int'(out_valid), 0);
        chk("midrun out_iter holds previous", int'(out_iter), 1);
        periph_reset = 1'b1;
        #1;
        chk("midrun reset out_valid", int'(out_valid), 0);
        chk("midrun reset out_iter", int'(out_iter), 0);
        chk("midrun reset out_first", int'(out_first), 0);
        chk("midrun reset out_last", int'(out_last), 0);
        chk("midrun reset in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("midrun reset in_ready held", int'(in_ready), 0);
        periph_reset = 1'b0;
        #1;
        chk("midrun in_ready after release", int'(in_ready), 1);
        r = '{-320, 240, 1, 0, 16, 0, 0, 0, 3, 5};
        apply(r, "post-reset");

`ifdef MANDEL_ITER_PREFETCH_EN
        // Two back-to-back fast-escape pixels; the second parks in the hold.
        r = vt[1];
        set_pixel(r);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("pf in_ready during MAP", int'(in_ready), 1);
        in_first = 1'b1;
        in_last  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pf in_ready hold full", int'(in_ready), 0);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pf first latency", lat, 4);
        chk("pf first out_iter", int'(out_iter), 2);
        chk("pf first out_last", int'(out_last), 1);
        @(posedge clk); #1;
        chk("pf in_ready hold drained", int'(in_ready), 1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pf second gap", lat, 4);
        chk("pf second out_iter", int'(out_iter), 2);
        chk("pf second out_first", int'(out_first), 1);
        chk("pf second out_last", int'(out_last), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pf out_valid after second", int'(out_valid), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
